// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type, opcode/function field
// constants used by the fetch stage, and the PC-relative branch offset table.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_t;

  // Major opcodes whose func field selects the operation.
  localparam logic [2:0] OP_HASFUNCA = 3'b110;
  localparam logic [2:0] OP_HASFUNCB = 3'b111;

  // Func codes resolved in the fetch stage.
  localparam logic [2:0] FN_HALT = 3'b111;  // under OP_HASFUNCA
  localparam logic [2:0] FN_BNO  = 3'b000;  // under OP_HASFUNCB
  localparam logic [2:0] FN_BOF  = 3'b001;  // under OP_HASFUNCB

  // Signed 8-bit PC-relative branch offsets, indexed by the operand field.
  localparam logic signed [7:0] BR_OFFS [0:7] = '{
    8'sd2, 8'sd4, -8'sd2, -8'sd4, 8'sd8, -8'sd8, 8'sd16, -8'sd16
  };

endpackage

// File: rtl/branch_lut.sv
// Branch offset lookup: maps the 3-bit operand field of a branch instruction
// to its signed 8-bit PC-relative offset.
// Ports:
//   idx  - operand field of the branch instruction
//   offs - signed branch offset (two's complement)
module branch_lut
  import cpu_pkg::*;
(
  input  logic        [2:0] idx,
  output logic signed [7:0] offs
);

  assign offs = BR_OFFS[idx];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and branch stage. Addresses a combinational instruction
// ROM, forwards the opcode of the fetched instruction to the ALU, and
// resolves HALT and the overflow-conditioned branches (BOF/BNO) with no
// bubbles, using the ALU's registered overflow flag.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - pulse: begin (or restart) execution at address 0
//   instr       - ROM word at address pc, valid in the same cycle
//   ov_flag     - ALU overflow flag from the previously issued instruction
//   pc          - current fetch address
//   opcode      - instr[8:3] while instr_valid, else zero
//   instr_valid - high while running; qualifies opcode for the ALU
//   done        - high once a HALT has been executed
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               ov_flag,
  output logic [PC_W-1:0]    pc,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic               done
);

  fetch_state_t state_q, state_d;
  logic [PC_W-1:0] pc_d;

  // Instruction fields.
  logic [2:0] op, fn, operand;
  assign op      = instr[INSTR_W-1 -: 3];
  assign fn      = instr[INSTR_W-4 -: 3];
  assign operand = instr[2:0];

  logic signed [7:0] br_offs;
  branch_lut u_branch_lut (
    .idx  (operand),
    .offs (br_offs)
  );

  // Offset sign-extended to PC width; the adds below truncate to PC_W,
  // which gives modulo-2^PC_W wrap in both directions.
  logic [PC_W-1:0] offs_ext, pc_seq, pc_tgt;
  assign offs_ext = {{(PC_W-8){br_offs[7]}}, br_offs};
  assign pc_seq   = pc + PC_W'(1);
  assign pc_tgt   = pc + offs_ext;

  logic is_halt, take_branch;
  assign is_halt     = (op == OP_HASFUNCA) && (fn == FN_HALT);
  // Unlisted func codes under OP_HASFUNCB fall through as NOPs.
  assign take_branch = (op == OP_HASFUNCB) &&
                       (((fn == FN_BOF) &&  ov_flag) ||
                        ((fn == FN_BNO) && !ov_flag));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and infers a latch.
    state_d = state_q;
    pc_d    = pc;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (is_halt) begin
          state_d = ST_HALTED;          // pc keeps pointing at the HALT
        end else if (take_branch) begin
          pc_d = pc_tgt;
        end else begin
          pc_d = pc_seq;
        end
      end
      ST_HALTED: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc      <= '0;
    end else begin
      state_q <= state_d;
      pc      <= pc_d;
    end
  end

  // Outputs decode directly from state so reset clears them immediately.
  assign instr_valid = (state_q == ST_RUN);
  assign done        = (state_q == ST_HALTED);
  assign opcode      = instr_valid ? instr[INSTR_W-1 -: 6] : 6'd0;

endmodule
